alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised execute stage that merges the register bank and ALU into one clocked block.
- Accepts one register-to-register instruction per valid/ready handshake and latches its operands.
- Computes single-cycle ops in one cycle and MUL iteratively, then writes the result back to the destination register.
- Reports result and flags with a one-cycle done pulse; an external load port lets the core or bench initialise registers.

Parameters:
- DATA_W, 32, register and ALU datapath width (≥4, power of two).
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register index width; must equal clog2(NUM_REGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept an instruction.
- opcode  input  4  operation select.
- rs1  input  ADDR_W  source register A index.
- rs2  input  ADDR_W  source register B index.
- rd  input  ADDR_W  destination register index.
- ext_we  input  1  external register write enable.
- ext_waddr  input  ADDR_W  external write index.
- ext_wdata  input  DATA_W  external write data.
- dbg_raddr  input  ADDR_W  debug read index.
- dbg_rdata  output  DATA_W  combinational read of registers[dbg_raddr].
- done  output  1  one-cycle pulse at writeback.
- result  output  DATA_W  last completed result, held between ops.
- zero  output  1  result == 0.
- carry  output  1  ADD carry-out or SUB borrow; 0 for other ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 for other ops.
- illegal  output  1  pulses with done for a reserved opcode.
- busy  output  1  high in EXEC and MUL states.

Behaviour:
- Reset: all registers 0; state IDLE; in_ready=1; done=0, result=0, zero=0, carry=0, overflow=0, illegal=0, busy=0.
- Reset mid-operation: op aborted, no writeback, no done.
- Handshake: accept at the rising edge where in_valid && in_ready.
  - rs1/rs2 register values, opcode and rd are latched at that edge.
  - in_ready=0 while busy.
- Opcodes:
  - 0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = B[clog2(DATA_W)-1:0].
  - 8 SLT (signed, result 1/0); 9 SLTU (unsigned); A MUL (low DATA_W bits of A*B).
  - B-F reserved.
- States:
  - IDLE: on accept, go to MUL if opcode==A, else EXEC.
  - EXEC: one cycle; at its closing edge write registers[rd], update result and flags, set done=1, then return to IDLE.
  - MUL: shift-add, one multiplier bit per cycle, DATA_W cycles; the closing edge of the last iteration performs writeback exactly as EXEC does.
- Latency, counted from accept edge E0:
  - single-cycle ops: writeback and done at E1;
  - MUL: writeback and done at E(DATA_W).
  - done is high for exactly one cycle, and in_ready is high in that same cycle. Next accept is earliest at E2 (non-MUL), so back-to-back dependent ops see the written value.
- Reserved opcode: EXEC path, done=1 with illegal=1, no register write; result and flags unchanged.
- Flags:
  - zero/carry/overflow registered together with result.
  - carry for SUB = (A < B unsigned).
  - overflow = sign-based two's-complement rule.
- Write ports:
  - ALU writeback and ext write are independent.
  - Same index on the same edge: ALU writeback wins and the ext write is dropped.
  - An ext write to a source register after accept does not affect the in-flight op (operands already latched).
- dbg_rdata reflects the value after the edge (no bypass of same-cycle writes).

Test Plan:
- Reset, then ext-write R1=7, R2=5. ADD rd=3 → done at E1, R3=12, zero=0, carry=0; in_ready low for exactly one cycle.
- SUB R2-R1 (5-7) into R4 → R4=0xFFFFFFFE, carry=1, overflow=0. Then R1=0x7FFFFFFF, R2=1, ADD → result 0x80000000, overflow=1.
- MUL R1=6, R2=9 → busy for 32 cycles, done at E32, R5=54, in_ready=0 throughout; then SRA of 0x80000000 by 4 → 0xF8000000.
- Same-edge ALU writeback to R3 and ext_we to R3 with 0xDEAD → R3 holds the ALU result. Ext write to R6 on that edge succeeds.
- Opcode 0xC → done=1, illegal=1, registers and result unchanged. Assert rst at cycle 10 of a MUL → no done, target register unchanged, in_ready=1 the next cycle.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage holding the register bank and an ALU with an iterative shift-add multiplier.
module alu_exec_unit #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              illegal,
  output logic              busy
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;
  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] a_q, b_q, acc_q, result_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [SH_W-1:0]   cnt_q;
  logic              done_q, zero_q, carry_q, ovf_q, illegal_q;
  logic [DATA_W:0]   add_w, sub_w;
  logic [DATA_W-1:0] mul_d, alu_d;
  logic [SH_W-1:0]   sh;
  logic              carry_d, ovf_d, legal_d, last_mul, wb;
  assign add_w    = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w    = {1'b0, a_q} - {1'b0, b_q};
  assign sh       = b_q[SH_W-1:0];
  // During MUL, a_q holds the left-shifted multiplicand and b_q the right-shifted multiplier
  assign mul_d    = acc_q + (b_q[0] ? a_q : '0);
  assign last_mul = (state_q == MUL) && (cnt_q == SH_W'(DATA_W - 1));
  assign wb       = (state_q == EXEC && legal_d) || last_mul;
  always_comb begin
    alu_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    legal_d = 1'b1;
    case (op_q)
      4'h0: begin
        alu_d   = add_w[MSB:0];
        carry_d = add_w[DATA_W];
        ovf_d   = (a_q[MSB] == b_q[MSB]) && (add_w[MSB] != a_q[MSB]);
      end
      4'h1: begin
        alu_d   = sub_w[MSB:0];
        carry_d = sub_w[DATA_W];
        ovf_d   = (a_q[MSB] != b_q[MSB]) && (sub_w[MSB] != a_q[MSB]);
      end
      4'h2: alu_d = a_q & b_q;
      4'h3: alu_d = a_q | b_q;
      4'h4: alu_d = a_q ^ b_q;
      4'h5: alu_d = a_q << sh;
      4'h6: alu_d = a_q >> sh;
      4'h7: alu_d = $unsigned($signed(a_q) >>> sh);
      4'h8: alu_d = DATA_W'($signed(a_q) < $signed(b_q));
      4'h9: alu_d = DATA_W'(a_q < b_q);
      4'hA: alu_d = mul_d;
      default: legal_d = 1'b0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      if (ext_we) regs_q[ext_waddr] <= ext_wdata;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= regs_q[rs1];
          b_q     <= regs_q[rs2];
          op_q    <= opcode;
          rd_q    <= rd;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= (opcode == 4'hA) ? MUL : EXEC;
        end
        EXEC: begin
          done_q    <= 1'b1;
          illegal_q <= !legal_d;
          state_q   <= IDLE;
        end
        MUL: begin
          acc_q <= mul_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last_mul) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Placed after the ext write so the ALU wins a same-index collision
      if (wb) begin
        regs_q[rd_q] <= alu_d;
        result_q     <= alu_d;
        zero_q       <= (alu_d == '0);
        carry_q      <= carry_d;
        ovf_q        <= ovf_d;
      end
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign dbg_rdata = regs_q[dbg_raddr];
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign illegal   = illegal_q;
endmodule
